// File: rtl/write_back.sv
// Write-back stage of the dual-issue pipeline.
// Selects the load word for the upper (older) slot, takes the ALU result for
// the lower (younger) slot, resolves same-destination conflicts in favour of
// the younger slot, and registers both register-file write ports. A retired
// instruction counter and a sticky halt flag are kept alongside.
module write_back #(
  parameter logic [2:0] NOP_OP  = 3'b111,
  parameter logic [2:0] HALT_OP = 3'b110,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             interlock,
  input  logic [63:0]      inst,
  input  logic [4:0]       u_rt,
  input  logic             u_rt_flag,
  input  logic             u_ld_hi,
  input  logic [63:0]      mem_doutb,
  input  logic [31:0]      l_tdata,
  input  logic [4:0]       l_rt,
  input  logic             l_rt_flag,
  output logic             rf_we_u,
  output logic [4:0]       rf_wa_u,
  output logic [31:0]      rf_wd_u,
  output logic             rf_we_l,
  output logic [4:0]       rf_wa_l,
  output logic [31:0]      rf_wd_l,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  logic [2:0]       u_op;
  logic [2:0]       l_op;
  logic             u_valid;
  logic             l_valid;
  logic             u_halt;
  logic             l_halt;
  logic             we_u_next;
  logic             we_l_next;
  logic             conflict;
  logic [31:0]      ld_word;
  logic [CNT_W-1:0] retire_inc;

  assign u_op = inst[63:61];
  assign l_op = inst[31:29];

  // Decide which halves retire this cycle and what each one writes.
  // An upper-slot halt kills the younger lower half of the same pair.
  always_comb begin
    u_valid    = 1'b0;
    l_valid    = 1'b0;
    u_halt     = 1'b0;
    l_halt     = 1'b0;
    we_u_next  = 1'b0;
    we_l_next  = 1'b0;
    conflict   = 1'b0;
    ld_word    = mem_doutb[31:0];
    retire_inc = '0;

    if (u_ld_hi) begin
      ld_word = mem_doutb[63:32];
    end

    u_valid = (u_op != NOP_OP) && !interlock && !halted;
    u_halt  = u_valid && (u_op == HALT_OP);
    l_valid = (l_op != NOP_OP) && !interlock && !halted && !u_halt;
    l_halt  = l_valid && (l_op == HALT_OP);

    we_u_next = u_rt_flag && u_valid && (u_rt != 5'd0);
    we_l_next = l_rt_flag && l_valid && (l_rt != 5'd0);
    conflict  = we_u_next && we_l_next && (u_rt == l_rt);

    retire_inc = CNT_W'(u_valid) + CNT_W'(l_valid);
  end

  // Register both write ports; the younger slot wins a shared destination.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_we_u <= 1'b0;
      rf_wa_u <= 5'd0;
      rf_wd_u <= 32'd0;
      rf_we_l <= 1'b0;
      rf_wa_l <= 5'd0;
      rf_wd_l <= 32'd0;
    end else begin
      rf_we_u <= we_u_next && !conflict;
      rf_wa_u <= u_rt;
      rf_wd_u <= ld_word;
      rf_we_l <= we_l_next;
      rf_wa_l <= l_rt;
      rf_wd_l <= l_tdata;
    end
  end

  // Count retired halves and latch the halt flag; both freeze once halted
  // because no half is valid from then on.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired <= '0;
      halted  <= 1'b0;
    end else begin
      retired <= retired + retire_inc;
      halted  <= halted || u_halt || l_halt;
    end
  end

endmodule

// File: tb/tb_write_back.sv
// Testbench for write_back: directed vectors push hand-computed expectations
// into a queue, and a monitor pops and compares one entry per output cycle.
module tb_write_back;

  localparam logic [31:0] H_ALU  = 32'h0000_0000;
  localparam logic [31:0] H_NOP  = 32'hE000_0000;
  localparam logic [31:0] H_HALT = 32'hC000_0000;
  localparam logic [63:0] MEMV   = 64'hDEADBEEF_12345678;

  logic        clk;
  logic        rstn;
  logic        interlock;
  logic [63:0] inst;
  logic [4:0]  u_rt;
  logic        u_rt_flag;
  logic        u_ld_hi;
  logic [63:0] mem_doutb;
  logic [31:0] l_tdata;
  logic [4:0]  l_rt;
  logic        l_rt_flag;
  logic        rf_we_u;
  logic [4:0]  rf_wa_u;
  logic [31:0] rf_wd_u;
  logic        rf_we_l;
  logic [4:0]  rf_wa_l;
  logic [31:0] rf_wd_l;
  logic [31:0] retired;
  logic        halted;

  logic        s_rstn;
  logic [63:0] s_inst;
  logic        s_we_u;
  logic [4:0]  s_wa_u;
  logic [31:0] s_wd_u;
  logic        s_we_l;
  logic [4:0]  s_wa_l;
  logic [31:0] s_wd_l;
  logic [3:0]  s_retired;
  logic        s_halted;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic        we_u;
    logic [4:0]  wa_u;
    logic [31:0] wd_u;
    logic        we_l;
    logic [4:0]  wa_l;
    logic [31:0] wd_l;
    logic [31:0] ret;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];

  write_back dut (
    .clk       (clk),
    .rstn      (rstn),
    .interlock (interlock),
    .inst      (inst),
    .u_rt      (u_rt),
    .u_rt_flag (u_rt_flag),
    .u_ld_hi   (u_ld_hi),
    .mem_doutb (mem_doutb),
    .l_tdata   (l_tdata),
    .l_rt      (l_rt),
    .l_rt_flag (l_rt_flag),
    .rf_we_u   (rf_we_u),
    .rf_wa_u   (rf_wa_u),
    .rf_wd_u   (rf_wd_u),
    .rf_we_l   (rf_we_l),
    .rf_wa_l   (rf_wa_l),
    .rf_wd_l   (rf_wd_l),
    .retired   (retired),
    .halted    (halted)
  );

  // Narrow-counter instance so the wrap of the retired count is reachable.
  write_back #(.CNT_W(4)) dut_small (
    .clk       (clk),
    .rstn      (s_rstn),
    .interlock (1'b0),
    .inst      (s_inst),
    .u_rt      (5'd0),
    .u_rt_flag (1'b0),
    .u_ld_hi   (1'b0),
    .mem_doutb (64'd0),
    .l_tdata   (32'd0),
    .l_rt      (5'd0),
    .l_rt_flag (1'b0),
    .rf_we_u   (s_we_u),
    .rf_wa_u   (s_wa_u),
    .rf_wd_u   (s_wd_u),
    .rf_we_l   (s_we_l),
    .rf_wa_l   (s_wa_l),
    .rf_wd_l   (s_wd_l),
    .retired   (s_retired),
    .halted    (s_halted)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  // Drive one pair at the falling edge and queue what it must produce.
  task automatic applyStimulus(
    input string name, input logic il, input logic [63:0] inst_v,
    input logic [4:0] urt, input logic uflag, input logic uhi,
    input logic [31:0] ltd, input logic [4:0] lrt, input logic lflag,
    input logic e_we_u, input logic [4:0] e_wa_u, input logic [31:0] e_wd_u,
    input logic e_we_l, input logic [4:0] e_wa_l, input logic [31:0] e_wd_l,
    input logic [31:0] e_ret, input logic e_halt);
    exp_t e;
    @(negedge clk);
    interlock = il;
    inst      = inst_v;
    u_rt      = urt;
    u_rt_flag = uflag;
    u_ld_hi   = uhi;
    mem_doutb = MEMV;
    l_tdata   = ltd;
    l_rt      = lrt;
    l_rt_flag = lflag;
    e.name = name;
    e.we_u = e_we_u; e.wa_u = e_wa_u; e.wd_u = e_wd_u;
    e.we_l = e_we_l; e.wa_l = e_wa_l; e.wd_l = e_wd_l;
    e.ret  = e_ret;  e.halt = e_halt;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic driveIdle();
    interlock = 1'b0;
    inst      = {H_NOP, H_NOP};
    u_rt      = 5'd0;
    u_rt_flag = 1'b0;
    u_ld_hi   = 1'b0;
    mem_doutb = 64'd0;
    l_tdata   = 32'd0;
    l_rt      = 5'd0;
    l_rt_flag = 1'b0;
  endtask

  task automatic drainQueue();
    int budget;
    budget = 5;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_we_u"}, {31'd0, rf_we_u}, 32'd0);
    checkOutput({tag, "_wa_u"}, {27'd0, rf_wa_u}, 32'd0);
    checkOutput({tag, "_wd_u"}, rf_wd_u, 32'd0);
    checkOutput({tag, "_we_l"}, {31'd0, rf_we_l}, 32'd0);
    checkOutput({tag, "_wa_l"}, {27'd0, rf_wa_l}, 32'd0);
    checkOutput({tag, "_wd_l"}, rf_wd_l, 32'd0);
    checkOutput({tag, "_retired"}, retired, 32'd0);
    checkOutput({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  // Monitor: one output cycle per queued expectation, sampled after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_we_u"}, {31'd0, rf_we_u}, {31'd0, e.we_u});
        if (e.we_u) begin
          checkOutput({e.name, "_wa_u"}, {27'd0, rf_wa_u}, {27'd0, e.wa_u});
          checkOutput({e.name, "_wd_u"}, rf_wd_u, e.wd_u);
        end
        checkOutput({e.name, "_we_l"}, {31'd0, rf_we_l}, {31'd0, e.we_l});
        if (e.we_l) begin
          checkOutput({e.name, "_wa_l"}, {27'd0, rf_wa_l}, {27'd0, e.wa_l});
          checkOutput({e.name, "_wd_l"}, rf_wd_l, e.wd_l);
        end
        checkOutput({e.name, "_retired"}, retired, e.ret);
        checkOutput({e.name, "_halted"}, {31'd0, halted}, {31'd0, e.halt});
      end
    end
  end

  // Directed sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    s_rstn   = 1'b0;
    s_inst   = {H_NOP, H_NOP};
    driveIdle();
    #12;
    checkResetState("por");
    @(negedge clk);
    rstn = 1'b1;

    applyStimulus("ld_hi", 0, {H_ALU, H_NOP}, 5'd5, 1, 1, 32'h0, 5'd0, 0,
                  1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 32'd1, 0);
    applyStimulus("ld_lo", 0, {H_ALU, H_NOP}, 5'd5, 1, 0, 32'h0, 5'd0, 0,
                  1, 5'd5, 32'h12345678, 0, 5'd0, 32'h0, 32'd2, 0);
    applyStimulus("dual", 0, {H_ALU, H_ALU}, 5'd7, 1, 1, 32'h11, 5'd9, 1,
                  1, 5'd7, 32'hDEADBEEF, 1, 5'd9, 32'h11, 32'd4, 0);
    applyStimulus("conflict", 0, {H_ALU, H_ALU}, 5'd7, 1, 1, 32'h11, 5'd7, 1,
                  0, 5'd0, 32'h0, 1, 5'd7, 32'h11, 32'd6, 0);
    applyStimulus("nop_pair", 0, {H_NOP, H_NOP}, 5'd7, 1, 1, 32'h11, 5'd9, 1,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'd6, 0);
    applyStimulus("r0_lower", 0, {H_ALU, H_ALU}, 5'd5, 1, 0, 32'h22, 5'd0, 1,
                  1, 5'd5, 32'h12345678, 0, 5'd0, 32'h0, 32'd8, 0);
    applyStimulus("interlock", 1, {H_ALU, H_ALU}, 5'd7, 1, 1, 32'h11, 5'd9, 1,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'd8, 0);
    applyStimulus("lower_only", 0, {H_NOP, H_ALU}, 5'd0, 0, 0, 32'h33, 5'd3, 1,
                  0, 5'd0, 32'h0, 1, 5'd3, 32'h33, 32'd9, 0);
    drainQueue();

    // Asynchronous reset while the lower port is actively writing.
    @(posedge clk);
    #1;
    checkOutput("pre_reset_we_l", {31'd0, rf_we_l}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkResetState("async_rst");
    driveIdle();
    @(negedge clk);
    rstn = 1'b1;

    applyStimulus("post_rst", 0, {H_ALU, H_ALU}, 5'd4, 1, 0, 32'h55, 5'd6, 1,
                  1, 5'd4, 32'h12345678, 1, 5'd6, 32'h55, 32'd2, 0);
    applyStimulus("halt_up", 0, {H_HALT, H_ALU}, 5'd0, 0, 0, 32'h77, 5'd3, 1,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'd3, 1);
    applyStimulus("after_halt", 0, {H_ALU, H_ALU}, 5'd7, 1, 1, 32'h11, 5'd9, 1,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'd3, 1);
    drainQueue();

    // Lower-half halt: the upper half still retires and writes.
    @(negedge clk);
    rstn = 1'b0;
    driveIdle();
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus("halt_lo", 0, {H_ALU, H_HALT}, 5'd8, 1, 0, 32'h0, 5'd0, 0,
                  1, 5'd8, 32'h12345678, 0, 5'd0, 32'h0, 32'd2, 1);
    applyStimulus("halt_lo_frz", 0, {H_ALU, H_ALU}, 5'd8, 1, 1, 32'h44, 5'd2, 1,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'd2, 1);
    drainQueue();

    // Counter wrap on the 4-bit instance: 7 pairs + 1 half = 15, then a pair.
    @(negedge clk);
    s_rstn = 1'b1;
    s_inst = {H_ALU, H_ALU};
    repeat (7) @(negedge clk);
    s_inst = {H_ALU, H_NOP};
    @(negedge clk);
    checkOutput("cnt_at_max", {28'd0, s_retired}, 32'd15);
    s_inst = {H_ALU, H_ALU};
    @(negedge clk);
    checkOutput("cnt_wrap", {28'd0, s_retired}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Final stage of the dual-issue pipeline; sits directly downstream of the memory stage.
- Consumes the upper-slot (load) and lower-slot (ALU) results, selects the 32-bit load word, and resolves same-cycle destination conflicts.
- Drives the two register-file write ports with a one-cycle registered latency.
- Also maintains a retired-instruction counter and a sticky halt flag.

Parameters:
- NOP_OP, 3'b111, opcode in bits [31:29] of a 32-bit half that marks a bubble/nop.
- HALT_OP, 3'b110, opcode in bits [31:29] of a 32-bit half that marks halt.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- interlock  in  1  pipeline stall; when high, stage inputs are invalid.
- inst  in  64  instruction pair; [63:32] upper slot (older), [31:0] lower slot (younger).
- u_rt  in  5  upper-slot destination register.
- u_rt_flag  in  1  upper slot writes a register (load).
- u_ld_hi  in  1  1: load word = mem_doutb[63:32]; 0: load word = mem_doutb[31:0].
- mem_doutb  in  64  read data from memory stage.
- l_tdata  in  32  lower-slot ALU result.
- l_rt  in  5  lower-slot destination register.
- l_rt_flag  in  1  lower slot writes a register.
- rf_we_u  out  1  upper write enable.
- rf_wa_u  out  5  upper write address.
- rf_wd_u  out  32  upper write data.
- rf_we_l  out  1  lower write enable.
- rf_wa_l  out  5  lower write address.
- rf_wd_l  out  32  lower write data.
- retired  out  CNT_W  count of retired non-nop instruction halves.
- halted  out  1  sticky; set once a halt half retires.

Behaviour:
- Reset (async, rstn low): rf_we_u=0, rf_we_l=0, rf_wa_*=0, rf_wd_*=0, retired=0, halted=0. Takes effect immediately regardless of clk. First capture occurs on the first posedge after rstn rises.
- Latency: inputs sampled at posedge N appear on rf_* outputs after posedge N, i.e. valid for cycle N+1. Every output is registered.
- Half valid: a half is valid when its opcode [31:29] != NOP_OP, interlock=0, and halted=0.
- Upper write: we_u_next = u_rt_flag & upper valid & (u_rt != 0).
  - wd = mem_doutb[63:32] if u_ld_hi, else mem_doutb[31:0].
- Lower write: we_l_next = l_rt_flag & lower valid & (l_rt != 0); wd = l_tdata.
- Same-destination conflict: if we_u_next and we_l_next both set and u_rt == l_rt, the lower (younger) slot wins and rf_we_u is driven 0. rf_wa_u and rf_wd_u still update; they are don't-care for checking.
- Register 0: writes are never enabled for address 0.
- Interlock high: rf_we_u=rf_we_l=0 for the next cycle; retired and halted hold. Address and data registers may update; they are don't-care.
- Retired counter: adds the number of valid halves (0, 1 or 2) each non-interlocked cycle. A halt half counts. Wraps modulo 2^CNT_W with no saturation.
- Halt, upper half: if the upper half is valid with opcode HALT_OP, halted is set at that posedge. The lower half of the same pair is treated as invalid (no write, not counted).
- Halt, lower half: if only the lower half is HALT_OP, the upper half retires normally and then halted is set.
- After halt: halted stays 1 until reset. All further writes are suppressed and retired is frozen.
- Simultaneous reset and halt: reset wins.

Test Plan:
- Reset behaviour: rstn low mid-cycle while rf_we_l=1 -> all outputs 0 immediately; retired=0; halted=0.
- Load half select: upper load, u_rt=5, u_ld_hi=1, mem_doutb=64'hDEADBEEF_12345678 -> next cycle rf_we_u=1, rf_wa_u=5, rf_wd_u=32'hDEADBEEF. With u_ld_hi=0 -> rf_wd_u=32'h12345678.
- Dual write and conflict:
  - u_rt=7, l_rt=9, both flags set, l_tdata=32'h11 -> both write enables 1; retired +2.
  - Same pair with l_rt=7 -> rf_we_u=0, rf_we_l=1, rf_wd_l=32'h11.
- Nop, r0 and interlock:
  - inst={3'b111,29'b0, 3'b111,29'b0} -> no writes, retired unchanged.
  - Valid pair with l_rt=0 -> rf_we_l=0, retired still +2.
  - interlock=1 with a valid pair -> no writes, retired unchanged.
- Halt:
  - Upper half HALT_OP, lower half valid ALU write to r3 -> no r3 write, retired +1, halted=1. Subsequent valid pairs produce no writes and no counting.
- Counter wrap: preload retired to 32'hFFFFFFFF (via CNT_W-wide run or force) then a valid pair -> retired=32'h00000001.
